// File: rtl/adiabatic_pclk_gen.sv
// Sequencer for 4-phase adiabatic power clocks, two stages a quarter apart.
// Optional ADCLK_STALL_EN adds a stall input that freezes at quarter edges.
module adiabatic_pclk_gen #(
   parameter  int STEPS  = 4,
   localparam int STEP_W = $clog2(STEPS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
`ifdef ADCLK_STALL_EN
   input  logic              stall,
`endif
   output logic [STEP_W-1:0] clkpos_lvl,
   output logic [STEP_W-1:0] clkneg_lvl,
   output logic [STEP_W-1:0] clkpos2_lvl,
   output logic [STEP_W-1:0] clkneg2_lvl,
   output logic [1:0]        quarter,
   output logic              busy,
   output logic              cycle_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   localparam logic [STEP_W-1:0] SMAX  = STEP_W'(STEPS);
   localparam logic [STEP_W-1:0] SLAST = STEP_W'(STEPS - 1);

   state_t            r_state;
   state_t            w_n_state;
   logic [1:0]        r_q;
   logic [1:0]        w_n_q;
   logic [STEP_W-1:0] r_s;
   logic [STEP_W-1:0] w_n_s;
   logic              w_hold;
   logic              w_last;
   logic              w_active;
   logic              w_n_done;
   logic [STEP_W-1:0] w_lvl1;
   logic [STEP_W-1:0] w_lvl2;

   function automatic logic [STEP_W-1:0] f_lvl(
      input logic [1:0]        q,
      input logic [STEP_W-1:0] s
   );
      logic [STEP_W-1:0] v;
      unique case (q)
         2'd0: v = s + STEP_W'(1);
         2'd1: v = SMAX;
         2'd2: v = SLAST - s;
         2'd3: v = '0;
      endcase
      return v;
   endfunction

   always_comb begin
      w_last = (r_q == 2'd3) && (r_s == SLAST);
`ifdef ADCLK_STALL_EN
      w_hold = stall && (r_s == SLAST) && (r_state != ST_IDLE);
`else
      w_hold = 1'b0;
`endif
      w_n_state = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_n_state = ST_RUN;
         ST_RUN:   if (stop) w_n_state = ST_DRAIN;
         ST_DRAIN: if (w_last && !w_hold) w_n_state = ST_IDLE;
         default:  w_n_state = ST_IDLE;
      endcase

      // Counters restart from zero on entry to RUN and on return to IDLE.
      w_n_q = r_q;
      w_n_s = r_s;
      if (r_state == ST_IDLE || w_n_state == ST_IDLE) begin
         w_n_q = 2'd0;
         w_n_s = '0;
      end else if (!w_hold) begin
         if (r_s == SLAST) begin
            w_n_s = '0;
            w_n_q = r_q + 2'd1;
         end else begin
            w_n_s = r_s + STEP_W'(1);
         end
      end

      w_active = (w_n_state != ST_IDLE);
      w_n_done = w_active && !w_hold &&
                 (w_n_q == 2'd3) && (w_n_s == SLAST);
      w_lvl1   = w_active ? f_lvl(w_n_q, w_n_s) : '0;
      w_lvl2   = w_active ? f_lvl(w_n_q - 2'd1, w_n_s) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_q         <= 2'd0;
         r_s         <= '0;
         clkpos_lvl  <= '0;
         clkneg_lvl  <= SMAX;
         clkpos2_lvl <= '0;
         clkneg2_lvl <= SMAX;
         quarter     <= 2'd0;
         busy        <= 1'b0;
         cycle_done  <= 1'b0;
      end else begin
         r_state     <= w_n_state;
         r_q         <= w_n_q;
         r_s         <= w_n_s;
         clkpos_lvl  <= w_lvl1;
         clkneg_lvl  <= SMAX - w_lvl1;
         clkpos2_lvl <= w_lvl2;
         clkneg2_lvl <= SMAX - w_lvl2;
         quarter     <= w_n_q;
         busy        <= w_active;
         cycle_done  <= w_n_done;
      end
   end

endmodule
